// File: rtl/mod_bit_grouper.sv
// mod_bit_grouper: collects serial scrambler bits into Qm-bit symbol groups
// (BPSK..256QAM) and hands them to the modulation mapper through a small
// valid/ready FIFO. A flush closes a trailing partial group with zero padding.
module mod_bit_grouper #(
  parameter int MAX_QM = 8,
  parameter int DEPTH  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [2:0]        Mod_Order,
  input  logic              SC_IN,
  input  logic              SC_Valid,
  output logic              SC_Ready,
  input  logic              Flush,
  output logic [MAX_QM-1:0] Mod_IN,
  output logic [3:0]        Mod_Qm,
  output logic              Mod_Pad,
  output logic              Mod_Valid,
  input  logic              Mod_Ready,
  output logic              Order_Err
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]       MAX_QM_C   = 4'(MAX_QM);
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE_C  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST_C = PTR_W'(DEPTH - 1);

  // Maps the order code to Qm; unknown codes or orders wider than the bus
  // fall back to one bit per symbol and raise the error flag (bit 4).
  function automatic logic [4:0] decode_order(input logic [2:0] order);
    logic [3:0] qm;
    logic       err;
    qm  = 4'd1;
    err = 1'b0;
    case (order)
      3'd0:    qm = 4'd1;
      3'd1:    qm = 4'd2;
      3'd2:    qm = 4'd4;
      3'd3:    qm = 4'd6;
      3'd4:    qm = 4'd8;
      default: begin
        qm  = 4'd1;
        err = 1'b1;
      end
    endcase
    if (qm > MAX_QM_C) begin
      qm  = 4'd1;
      err = 1'b1;
    end else begin
      err = err;
    end
    return {err, qm};
  endfunction

  // Group assembly state
  logic [3:0]        k_r;
  logic [3:0]        qm_r;
  logic [MAX_QM-1:0] asm_r;
  logic              flush_pending_r;
  logic              order_err_r;

  // FIFO storage and bookkeeping
  logic [MAX_QM-1:0] mem_data_r [DEPTH];
  logic [3:0]        mem_qm_r   [DEPTH];
  logic              mem_pad_r  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;

  logic              full_s;
  logic              sc_ready_s;
  logic              bit_accept_s;
  logic [4:0]        dec_s;
  logic [3:0]        grp_qm_s;
  logic [3:0]        k_inc_s;
  logic [MAX_QM-1:0] asm_shift_s;
  logic              group_done_s;
  logic              flush_push_s;
  logic              push_s;
  logic              pop_s;
  logic [MAX_QM-1:0] push_data_s;
  logic [3:0]        push_qm_s;
  logic              push_pad_s;

  assign full_s       = (count_r == DEPTH_C);
  assign sc_ready_s   = RST && !full_s && !flush_pending_r;
  assign bit_accept_s = SC_Valid && sc_ready_s;
  assign pop_s        = (count_r != {CNT_W{1'b0}}) && Mod_Ready;
  assign SC_Ready     = sc_ready_s;
  assign Order_Err    = order_err_r;

  // Decode the incoming bit: order is only honoured on the first bit of a group,
  // and a new group starts from a cleared register so unused high bits stay zero.
  always_comb begin
    dec_s    = decode_order(Mod_Order);
    k_inc_s  = k_r + 4'd1;
    grp_qm_s = qm_r;
    asm_shift_s = {asm_r[MAX_QM-2:0], SC_IN};
    if (k_r == 4'd0) begin
      grp_qm_s    = dec_s[3:0];
      asm_shift_s = {{(MAX_QM-1){1'b0}}, SC_IN};
    end else begin
      grp_qm_s    = qm_r;
      asm_shift_s = {asm_r[MAX_QM-2:0], SC_IN};
    end
    group_done_s = bit_accept_s && (k_inc_s == grp_qm_s);
    flush_push_s = flush_pending_r && (k_r != 4'd0) && !full_s;
  end

  // Select what enters the FIFO: a completed group, or a flushed partial group
  // left-aligned within its Qm field.
  always_comb begin
    push_s      = group_done_s || flush_push_s;
    push_data_s = {MAX_QM{1'b0}};
    push_qm_s   = 4'd0;
    push_pad_s  = 1'b0;
    if (group_done_s) begin
      push_data_s = asm_shift_s;
      push_qm_s   = grp_qm_s;
      push_pad_s  = 1'b0;
    end else if (flush_push_s) begin
      push_data_s = asm_r << (qm_r - k_r);
      push_qm_s   = qm_r;
      push_pad_s  = 1'b1;
    end else begin
      push_data_s = {MAX_QM{1'b0}};
      push_qm_s   = 4'd0;
      push_pad_s  = 1'b0;
    end
  end

  // Shift accepted bits into the assembly register and track the bit count.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      k_r   <= 4'd0;
      qm_r  <= 4'd0;
      asm_r <= {MAX_QM{1'b0}};
    end else if (bit_accept_s) begin
      asm_r <= asm_shift_s;
      qm_r  <= grp_qm_s;
      k_r   <= group_done_s ? 4'd0 : k_inc_s;
    end else if (flush_push_s) begin
      k_r   <= 4'd0;
      asm_r <= {MAX_QM{1'b0}};
    end
  end

  // Flush request holds off input until the partial group is closed or found empty.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      flush_pending_r <= 1'b0;
    end else if (Flush) begin
      flush_pending_r <= 1'b1;
    end else if (flush_pending_r && ((k_r == 4'd0) || flush_push_s)) begin
      flush_pending_r <= 1'b0;
    end
  end

  // Sticky illegal-order flag, sampled when a group latches its order.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      order_err_r <= 1'b0;
    end else if (bit_accept_s && (k_r == 4'd0) && dec_s[4]) begin
      order_err_r <= 1'b1;
    end
  end

  // FIFO entry storage.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data_r[i] <= {MAX_QM{1'b0}};
        mem_qm_r[i]   <= 4'd0;
        mem_pad_r[i]  <= 1'b0;
      end
    end else if (push_s) begin
      mem_data_r[wr_ptr_r] <= push_data_s;
      mem_qm_r[wr_ptr_r]   <= push_qm_s;
      mem_pad_r[wr_ptr_r]  <= push_pad_s;
    end
  end

  // FIFO pointers (wrapping at DEPTH) and occupancy count.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= (wr_ptr_r == PTR_LAST_C) ? {PTR_W{1'b0}} : wr_ptr_r + PTR_ONE_C;
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == PTR_LAST_C) ? {PTR_W{1'b0}} : rd_ptr_r + PTR_ONE_C;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE_C;
        2'b01:   count_r <= count_r - CNT_ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

  // Present the head entry; outputs read as zero whenever the FIFO is empty.
  always_comb begin
    Mod_Valid = (count_r != {CNT_W{1'b0}});
    if (Mod_Valid) begin
      Mod_IN  = mem_data_r[rd_ptr_r];
      Mod_Qm  = mem_qm_r[rd_ptr_r];
      Mod_Pad = mem_pad_r[rd_ptr_r];
    end else begin
      Mod_IN  = {MAX_QM{1'b0}};
      Mod_Qm  = 4'd0;
      Mod_Pad = 1'b0;
    end
  end

endmodule
